// File: rtl/fb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fb_pkg : shared frame-buffer constants and pixel-type encoding     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fb_pkg;

    localparam int SRC_WIDTH   = 320;
    localparam int SRC_HEIGHT  = 240;
    localparam int FRAME_WORDS = SRC_WIDTH * SRC_HEIGHT;
    localparam int ADDR_W      = 18;

    // Pixel type field (bits [7:6]) as decoded by the colour mux.
    localparam logic [1:0] PIX_DRAWN = 2'b11;
    localparam logic [1:0] PIX_GRAY  = 2'b00;

endpackage : fb_pkg
`default_nettype wire

// File: rtl/frame_scaler_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | frame_scaler_if : raster-in / BRAM / pixel-out bundle for the      |
// | frame_scaler read path.  rev 1.0                                   |
// +--------------------------------------------------------------------+
interface frame_scaler_if #(
    parameter int ADDR_W = fb_pkg::ADDR_W
);
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic              hsync;
    logic              vsync;
    logic              blank;
    logic              swap_req;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_data;
    logic [7:0]        scaled_pixel;
    logic              hsync_o;
    logic              vsync_o;
    logic              blank_o;
    logic              read_frame;
    logic              swap_ack;

    // Raster timing generator and frame-buffer memory side.
    modport master (
        output hcount, vcount, hsync, vsync, blank, swap_req, bram_data,
        input  bram_addr, scaled_pixel, hsync_o, vsync_o, blank_o,
               read_frame, swap_ack
    );

    // Scaler side.
    modport slave (
        input  hcount, vcount, hsync, vsync, blank, swap_req, bram_data,
        output bram_addr, scaled_pixel, hsync_o, vsync_o, blank_o,
               read_frame, swap_ack
    );
endinterface : frame_scaler_if
`default_nettype wire

// File: rtl/pipe_delay.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_delay : DEPTH-stage shift register with synchronous reset     |
// | to RESET_VAL.  rev 1.0                                             |
// +--------------------------------------------------------------------+
module pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule : pipe_delay
`default_nettype wire

// File: rtl/frame_scaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | frame_scaler : raster -> downscaled double-buffered BRAM address,  |
// | sync/blank aligned to read latency, buffer swap at image end. r1.0 |
// +--------------------------------------------------------------------+
module frame_scaler #(
    parameter int SRC_WIDTH    = fb_pkg::SRC_WIDTH,
    parameter int SRC_HEIGHT   = fb_pkg::SRC_HEIGHT,
    parameter int SCALE_SHIFT  = 1,
    parameter int BRAM_LATENCY = 2,
    parameter int ADDR_W       = fb_pkg::ADDR_W
) (
    input  wire logic              clk_in,
    input  wire logic              rst_in,
    input  wire logic [10:0]       hcount_in,
    input  wire logic [9:0]        vcount_in,
    input  wire logic              hsync_in,
    input  wire logic              vsync_in,
    input  wire logic              blank_in,
    input  wire logic              swap_req_in,
    output logic      [ADDR_W-1:0] bram_addr_out,
    input  wire logic [7:0]        bram_data_in,
    output logic      [7:0]        scaled_pixel_out,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   blank_out,
    output logic                   read_frame_out,
    output logic                   swap_ack_out
);
    import fb_pkg::*;

    localparam int         c_FRAME_WORDS = SRC_WIDTH * SRC_HEIGHT;
    localparam logic [9:0] c_SWAP_LINE   = 10'(SRC_HEIGHT << SCALE_SHIFT);
    // Control word order {hsync, vsync, blank, in_region}; idle = syncs high, blanked.
    localparam logic [3:0] c_CTRL_IDLE   = 4'b1110;

    logic [10:0]       w_x_src;
    logic [9:0]        w_y_src;
    logic [ADDR_W-1:0] w_x_ext;
    logic [ADDR_W-1:0] w_y_ext;
    logic [ADDR_W-1:0] w_base;
    logic              w_in_region;
    logic              w_swap_point;

    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [3:0]        ctrl_q;
    logic [3:0]        ctrl_dly;
    logic [7:0]        pixel_d, pixel_q;
    logic              hsync_q, vsync_q, blank_q;
    logic              read_frame_q, pending_q, swap_ack_q;

    assign w_x_src      = hcount_in >> SCALE_SHIFT;
    assign w_y_src      = vcount_in >> SCALE_SHIFT;
    assign w_x_ext      = ADDR_W'(w_x_src);
    assign w_y_ext      = ADDR_W'(w_y_src);
    assign w_in_region  = (w_x_ext < ADDR_W'(SRC_WIDTH)) && (w_y_ext < ADDR_W'(SRC_HEIGHT));
    assign w_base       = read_frame_q ? ADDR_W'(c_FRAME_WORDS) : '0;
    assign addr_d       = w_in_region ? (w_base + w_y_ext * ADDR_W'(SRC_WIDTH) + w_x_ext) : '0;
    assign w_swap_point = (vcount_in == c_SWAP_LINE) && (hcount_in == '0);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_q <= '0;
            ctrl_q <= c_CTRL_IDLE;
        end else begin
            addr_q <= addr_d;
            ctrl_q <= {hsync_in, vsync_in, blank_in, w_in_region};
        end
    end

    pipe_delay #(
        .WIDTH     (4),
        .DEPTH     (BRAM_LATENCY),
        .RESET_VAL (c_CTRL_IDLE)
    ) u_ctrl_dly (
        .clk_i (clk_in),
        .rst_i (rst_in),
        .d_i   (ctrl_q),
        .q_o   (ctrl_dly)
    );

    assign pixel_d = (ctrl_dly[1] || !ctrl_dly[0]) ? 8'h00 : bram_data_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pixel_q <= 8'h00;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b1;
        end else begin
            pixel_q <= pixel_d;
            hsync_q <= ctrl_dly[3];
            vsync_q <= ctrl_dly[2];
            blank_q <= ctrl_dly[1];
        end
    end

    // A request coinciding with the swap point is serviced without going pending.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            read_frame_q <= 1'b0;
            pending_q    <= 1'b0;
            swap_ack_q   <= 1'b0;
        end else if (w_swap_point && (pending_q || swap_req_in)) begin
            read_frame_q <= !read_frame_q;
            pending_q    <= 1'b0;
            swap_ack_q   <= 1'b1;
        end else begin
            swap_ack_q <= 1'b0;
            if (swap_req_in) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign bram_addr_out    = addr_q;
    assign scaled_pixel_out = pixel_q;
    assign hsync_out        = hsync_q;
    assign vsync_out        = vsync_q;
    assign blank_out        = blank_q;
    assign read_frame_out   = read_frame_q;
    assign swap_ack_out     = swap_ack_q;

endmodule : frame_scaler
`default_nettype wire

// File: tb/tb_frame_scaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_frame_scaler : directed scoreboard bench for frame_scaler       |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_frame_scaler;

    typedef struct {
        int         due;
        logic [7:0] pix;
        logic       hs;
        logic       vs;
        logic       bl;
        logic [7:0] pix0;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_scaler_if #(.ADDR_W(18)) vif ();

    logic [17:0] addr0;
    logic [7:0]  pix0;
    logic        hs0, vs0, bl0, rf0, ack0;

    frame_scaler u_dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .hcount_in        (vif.hcount),
        .vcount_in        (vif.vcount),
        .hsync_in         (vif.hsync),
        .vsync_in         (vif.vsync),
        .blank_in         (vif.blank),
        .swap_req_in      (vif.swap_req),
        .bram_addr_out    (vif.bram_addr),
        .bram_data_in     (vif.bram_data),
        .scaled_pixel_out (vif.scaled_pixel),
        .hsync_out        (vif.hsync_o),
        .vsync_out        (vif.vsync_o),
        .blank_out        (vif.blank_o),
        .read_frame_out   (vif.read_frame),
        .swap_ack_out     (vif.swap_ack)
    );

    // Unscaled instance fed constant 8'hFF data: only in-region gating is observed.
    frame_scaler #(.SCALE_SHIFT(0)) u_dut0 (
        .clk_in           (clk),
        .rst_in           (rst),
        .hcount_in        (vif.hcount),
        .vcount_in        (vif.vcount),
        .hsync_in         (vif.hsync),
        .vsync_in         (vif.vsync),
        .blank_in         (vif.blank),
        .swap_req_in      (vif.swap_req),
        .bram_addr_out    (addr0),
        .bram_data_in     (8'hFF),
        .scaled_pixel_out (pix0),
        .hsync_out        (hs0),
        .vsync_out        (vs0),
        .blank_out        (bl0),
        .read_frame_out   (rf0),
        .swap_ack_out     (ack0)
    );

    function automatic logic [7:0] pix_of(input logic [17:0] a);
        if (a == 18'd322)  return 8'hC0;
        if (a == 18'd3210) return 8'hFF;
        return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]};
    endfunction

    // Two-cycle BRAM read model.
    logic [7:0] bd1;
    always @(posedge clk) begin
        bd1           <= pix_of(vif.bram_addr);
        vif.bram_data <= bd1;
    end

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t sb[$];
    logic m_rf   = 1'b0;
    logic m_pend = 1'b0;
    logic m_ack  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("pixel",  32'(vif.scaled_pixel), 32'(e.pix));
            check("hsync",  32'(vif.hsync_o),      32'(e.hs));
            check("vsync",  32'(vif.vsync_o),      32'(e.vs));
            check("blank",  32'(vif.blank_o),      32'(e.bl));
            check("pixel0", 32'(pix0),             32'(e.pix0));
        end else begin
            n_chk++;
            n_fail++;
            $error("FAIL scoreboard observed=no_entry expected=entry_due_at_%0d", cyc);
        end
    endtask

    task automatic reset_dut(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            rst          = 1'b1;
            vif.hcount   = '0;
            vif.vcount   = '0;
            vif.hsync    = 1'b1;
            vif.vsync    = 1'b1;
            vif.blank    = 1'b1;
            vif.swap_req = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            m_rf = 1'b0; m_pend = 1'b0; m_ack = 1'b0;
            check("rst_addr",  32'(vif.bram_addr),    32'd0);
            check("rst_pixel", 32'(vif.scaled_pixel), 32'd0);
            check("rst_hsync", 32'(vif.hsync_o),      32'd1);
            check("rst_vsync", 32'(vif.vsync_o),      32'd1);
            check("rst_blank", 32'(vif.blank_o),      32'd1);
            check("rst_rf",    32'(vif.read_frame),   32'd0);
            check("rst_ack",   32'(vif.swap_ack),     32'd0);
        end
        sb.delete();
        for (int k = 1; k <= 3; k++) begin
            e.due = cyc + k; e.pix = 8'h00; e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b1; e.pix0 = 8'h00;
            sb.push_back(e);
        end
    endtask

    task automatic step(input int h, input int v, input logic hs, input logic vs,
                        input logic bl, input logic req);
        logic [17:0] xs, ys, ea;
        logic        inreg, inreg0;
        exp_t        e;
        xs     = 18'(h >> 1);
        ys     = 18'(v >> 1);
        inreg  = (xs < 18'd320) && (ys < 18'd240);
        ea     = inreg ? ((m_rf ? 18'd76800 : 18'd0) + ys * 18'd320 + xs) : 18'd0;
        inreg0 = (h < 320) && (v < 240);
        e.due  = cyc + 4;
        e.pix  = (!bl && inreg)  ? pix_of(ea) : 8'h00;
        e.hs   = hs;
        e.vs   = vs;
        e.bl   = bl;
        e.pix0 = (!bl && inreg0) ? 8'hFF : 8'h00;
        sb.push_back(e);

        rst          = 1'b0;
        vif.hcount   = 11'(h);
        vif.vcount   = 10'(v);
        vif.hsync    = hs;
        vif.vsync    = vs;
        vif.blank    = bl;
        vif.swap_req = req;
        @(posedge clk);
        #1;
        cyc++;

        check("addr", 32'(vif.bram_addr), 32'(ea));
        if ((v == 480) && (h == 0) && (m_pend || req)) begin
            m_rf = !m_rf; m_pend = 1'b0; m_ack = 1'b1;
        end else begin
            m_ack = 1'b0;
            if (req) m_pend = 1'b1;
        end
        check("read_frame", 32'(vif.read_frame), 32'(m_rf));
        check("swap_ack",   32'(vif.swap_ack),   32'(m_ack));
        pop_check();
    endtask

    initial begin
        reset_dut(3);

        // Address mapping, blanking, region edges, sync patterns.
        step(5,   3,   1, 1, 0, 0);
        step(20,  20,  1, 1, 1, 0);
        step(639, 479, 0, 1, 0, 0);
        step(640, 10,  1, 0, 0, 0);
        step(400, 100, 0, 0, 0, 0);
        step(100, 100, 1, 1, 0, 0);
        step(0,   500, 1, 1, 0, 0);
        repeat (4) step(0, 0, 1, 1, 1, 0);

        // Request mid-frame, swap at image end, new buffer base.
        step(10, 100, 1, 1, 0, 1);
        step(20, 200, 1, 1, 0, 0);
        step(0,  479, 1, 1, 0, 0);
        step(1,  480, 1, 1, 1, 0);
        step(0,  480, 1, 1, 1, 0);
        step(1,  480, 1, 1, 1, 0);
        step(0,  0,   1, 1, 0, 0);
        check("addr_frame1", 32'(vif.bram_addr), 32'd76800);

        // Request exactly at the swap point.
        step(0, 480, 1, 1, 1, 1);

        // Three requests collapse into one swap.
        step(5, 10, 1, 1, 0, 1);
        step(5, 20, 1, 1, 0, 1);
        step(5, 30, 1, 1, 0, 1);
        step(0, 480, 1, 1, 1, 0);
        step(1, 480, 1, 1, 1, 0);
        step(0, 480, 1, 1, 1, 0);

        // Request one cycle after the swap point waits for the next one.
        step(1, 480, 1, 1, 1, 1);
        step(0, 0,   1, 1, 0, 0);
        step(0, 480, 1, 1, 1, 0);

        // Reset with a swap pending discards the request.
        step(0,   50, 1, 1, 0, 1);
        step(100, 60, 0, 1, 0, 0);
        reset_dut(2);
        step(0, 480, 1, 1, 1, 0);
        step(7, 9,   1, 0, 0, 0);
        repeat (4) step(0, 0, 1, 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_frame_scaler
`default_nettype wire
